// File: rtl/sdram_clk_pkg.sv
// Shared state type and default timing for the SDRAM clock/reset sequencer.
// Default cycle counts assume a 50 MHz PLL reference clock.
package sdram_clk_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_PWRUP,
    ST_RUN,
    ST_FAULT
  } seq_state_e;

  localparam int DEF_NUM_DOMAINS      = 2;
  localparam int DEF_PLL_RST_CYC      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_STAGE_GAP_CYC    = 8;
  localparam int DEF_SDRAM_PWRUP_CYC  = 10000;
  localparam int DEF_MAX_RETRY        = 3;

  function automatic int max_i(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_clk_rst_seq_sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to clk_i.
// Both stages clear on the asynchronous active-low reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sdram_clk_rst_seq.sv
// PLL reset/lock supervisor with staged domain reset release,
// SDRAM power-up timing, lock-loss recovery and retry/fault handling.
module sdram_clk_rst_seq
  import sdram_clk_pkg::*;
#(
  parameter int NUM_DOMAINS      = DEF_NUM_DOMAINS,
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int STAGE_GAP_CYC    = DEF_STAGE_GAP_CYC,
  parameter int SDRAM_PWRUP_CYC  = DEF_SDRAM_PWRUP_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                   refclk_i,
  input  logic                   rst_ni,
  input  logic                   pll_locked_i,
  input  logic                   sw_relock_i,
  output logic                   pll_rst_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
  output logic                   sdram_pwrup_done_o,
  output logic                   ready_o,
  output logic                   fault_o,
  output logic                   relock_pulse_o,
  output logic [RW-1:0]          retry_cnt_o
);

  localparam int REL_CYC = NUM_DOMAINS * STAGE_GAP_CYC;
  localparam int MAXC = max_i(max_i(max_i(PLL_RST_CYC, LOCK_TIMEOUT_CYC),
                                    max_i(LOCK_STABLE_CYC, REL_CYC)),
                              max_i(SDRAM_PWRUP_CYC, 2));
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(REL_CYC - 1);
  localparam logic [CW-1:0] PWR_LAST =
    CW'((SDRAM_PWRUP_CYC > 0) ? SDRAM_PWRUP_CYC - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic pll_rst_q, pll_rst_d;
  logic done_q, done_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;
  logic pulse_q, pulse_d;
  logic lock_s;
  logic lost;

  sync_2ff #(
    .W(1)
  ) u_lock_sync (
    .clk_i (refclk_i),
    .rst_ni(rst_ni),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      dom_q     <= '0;
      pll_rst_q <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dom_q     <= dom_d;
      pll_rst_q <= pll_rst_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    pulse_d = 1'b0;
    lost    = 1'b0;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as success.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = (SDRAM_PWRUP_CYC == 0) ? ST_RUN : ST_PWRUP;
        end
      end
      ST_PWRUP: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (cnt_q == PWR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s || sw_relock_i) lost = 1'b1;
      end
      ST_FAULT: begin
        if (sw_relock_i) begin
          state_d = ST_PLL_RST;
          retry_d = '0;
          pulse_d = 1'b1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    if (lost) begin
      state_d = ST_PLL_RST;
      pulse_d = 1'b1;
    end
    if (state_d == ST_RUN) retry_d = '0;

    // Shared counter: clears on any state change, idles in RUN/FAULT.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN || state_q == ST_FAULT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    fault_d   = (state_d == ST_FAULT);
    ready_d   = (state_d == ST_RUN);
    done_d    = (state_d == ST_RUN);
    dom_d     = '0;
    if (state_d inside {ST_RELEASE, ST_PWRUP, ST_RUN}) begin
      dom_d = dom_q;
      if (state_q == ST_RELEASE) begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          if (cnt_q == CW'((i + 1) * STAGE_GAP_CYC - 1)) dom_d[i] = 1'b1;
        end
      end
    end
  end

  assign pll_rst_o          = pll_rst_q;
  assign domain_rst_n_o     = dom_q;
  assign sdram_pwrup_done_o = done_q;
  assign ready_o            = ready_q;
  assign fault_o            = fault_q;
  assign relock_pulse_o     = pulse_q;
  assign retry_cnt_o        = retry_q;

endmodule

// File: tb/tb_sdram_clk_rst_seq.sv
// Bench for sdram_clk_rst_seq: lock/relock stimulus arrays are replayed
// cycle by cycle against an interval-based timeline model of the sequence.
module tb_sdram_clk_rst_seq;

  localparam int P    = 4;
  localparam int T    = 20;
  localparam int S    = 8;
  localparam int G    = 2;
  localparam int W    = 10;
  localparam int MAXR = 2;
  localparam int N    = 3;
  localparam int NMAX = 512;
  localparam logic [9:0] RSTV = 10'b1_000_0_0_0_0_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic sw_relock = 1'b0;
  logic pll_rst;
  logic [N-1:0] dom;
  logic done, rdy, flt, pls;
  logic [1:0] rc;
  logic [9:0] obs;

  bit lk [NMAX];
  bit swv [NMAX];
  logic [9:0] ev [NMAX];
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sdram_clk_rst_seq #(
    .NUM_DOMAINS     (N),
    .PLL_RST_CYC     (P),
    .LOCK_TIMEOUT_CYC(T),
    .LOCK_STABLE_CYC (S),
    .STAGE_GAP_CYC   (G),
    .SDRAM_PWRUP_CYC (W),
    .MAX_RETRY       (MAXR)
  ) dut (
    .refclk_i          (clk),
    .rst_ni            (rst_n),
    .pll_locked_i      (pll_locked),
    .sw_relock_i       (sw_relock),
    .pll_rst_o         (pll_rst),
    .domain_rst_n_o    (dom),
    .sdram_pwrup_done_o(done),
    .ready_o           (rdy),
    .fault_o           (flt),
    .relock_pulse_o    (pls),
    .retry_cnt_o       (rc)
  );

  assign obs = {pll_rst, dom, done, rdy, flt, pls, rc};

  // Field order: pll_rst, domain_rst_n, pwrup_done, ready, fault, pulse, retry.
  function automatic logic [9:0] pk(bit pr, logic [2:0] d, bit dn, bit rd,
                                    bit f, logic [1:0] r);
    return {pr, d, dn, rd, f, 1'b0, r};
  endfunction

  // Synchronised lock as seen by the sequencer in cycle x.
  function automatic bit ls(int x);
    if (x < 2 || x - 2 >= NMAX) return 1'b0;
    return lk[x-2];
  endfunction

  function automatic int first_ls(bit v, int a, int b);
    for (int x = a; x <= b; x++) if (ls(x) == v) return x;
    return -1;
  endfunction

  function automatic int first_loss(int a, int rs, int nc);
    for (int x = a; x < nc; x++) begin
      if (!ls(x)) return x;
      if (x >= rs && swv[x]) return x;
    end
    return -1;
  endfunction

  function automatic int first_sw(int a, int nc);
    for (int x = a; x < nc; x++) if (swv[x]) return x;
    return -1;
  endfunction

  task automatic seg(int a, int b, bit pr, bit f, logic [1:0] r);
    for (int x = a; x <= b && x < NMAX; x++) ev[x] = pk(pr, 3'b000, 0, 0, f, r);
  endtask

  // Walk the timeline phase by phase, each phase length derived from
  // where the lock/relock stimulus first satisfies the phase's exit rule.
  task automatic build(int nc);
    int m, t0, h, lo, r, rs, c, e;
    bit pl, fin, rel;
    logic [1:0] rcv;
    logic [2:0] d;
    for (int x = 0; x < NMAX; x++) ev[x] = '0;
    m = 0; rcv = 2'd0; pl = 1'b0;
    while (m < nc) begin
      seg(m, m + P - 1, 1, 0, rcv);
      if (pl) ev[m][2] = 1'b1;
      pl = 1'b0;
      m += P;
      t0 = m; fin = 1'b0; rel = 1'b0;
      while (!fin) begin
        h = first_ls(1'b1, t0, t0 + T - 1);
        if (h < 0) begin
          seg(t0, t0 + T - 1, 0, 0, rcv);
          m = t0 + T; fin = 1'b1;
        end else begin
          seg(t0, h, 0, 0, rcv);
          lo = first_ls(1'b0, h + 1, h + S);
          seg(h + 1, (lo < 0) ? h + S : lo, 0, 0, rcv);
          if (lo < 0) begin
            m = h + S + 1; fin = 1'b1; rel = 1'b1;
          end else begin
            t0 = lo + 1;
          end
        end
      end
      if (m >= nc) break;
      if (rel) begin
        r = m; rs = r + N * G + W;
        c = first_loss(r, rs, nc);
        e = (c < 0) ? nc - 1 : c;
        for (int x = r; x <= e; x++) begin
          for (int i = 0; i < N; i++) d[i] = ((x - r) >= (i + 1) * G);
          ev[x] = pk(0, d, x >= rs, x >= rs, 0, (x >= rs) ? 2'd0 : rcv);
        end
        if (c >= rs) rcv = 2'd0;
        m = (c < 0) ? nc : c + 1;
        pl = 1'b1;
      end else if (rcv == 2'(MAXR)) begin
        c = first_sw(m, nc);
        e = (c < 0) ? nc - 1 : c;
        seg(m, e, 1, 1, rcv);
        rcv = 2'd0; pl = 1'b1;
        m = (c < 0) ? nc : c + 1;
      end else begin
        rcv = rcv + 2'd1;
      end
    end
  endtask

  task automatic chk(string tag, int cyc, logic [9:0] o, logic [9:0] x);
    ntests++;
    assert (o === x) else begin
      nfail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b (pr,dom,dn,rdy,flt,pls,rc)",
             tag, cyc, o, x);
    end
  endtask

  task automatic clear_stim();
    for (int x = 0; x < NMAX; x++) begin
      lk[x] = 1'b0;
      swv[x] = 1'b0;
    end
  endtask

  task automatic set_lk(int a, int b, bit v);
    for (int x = a; x <= b && x < NMAX; x++) lk[x] = v;
  endtask

  task automatic run_scn(string tag, int nc, int abort_at);
    build(nc);
    rst_n = 1'b0; pll_locked = 1'b0; sw_relock = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk({tag, "_inrst"}, -1, obs, RSTV);
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 0; m < nc; m++) begin
      if (m == abort_at) break;
      #1 chk(tag, m, obs, ev[m]);
      pll_locked = lk[m];
      sw_relock = swv[m];
      @(negedge clk);
    end
    if (abort_at >= 0) begin
      #2 rst_n = 1'b0;
      #1 chk({tag, "_async"}, abort_at, obs, RSTV);
      @(posedge clk);
      #1 chk({tag, "_held"}, abort_at, obs, RSTV);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len, x;
    bit v;

    clear_stim();
    set_lk(P + 5, NMAX - 1, 1'b1);
    run_scn("lock_basic", 80, -1);

    for (int k = 0; k < 3; k++) begin
      clear_stim();
      set_lk(P + $urandom_range(0, 14), NMAX - 1, 1'b1);
      run_scn("lock_rand", 80, -1);
    end

    clear_stim();
    r = P + 3;
    set_lk(r, NMAX - 1, 1'b1);
    lk[r+7] = 1'b0;
    run_scn("stable_glitch", 90, -1);

    clear_stim();
    r = P + $urandom_range(0, 4);
    set_lk(r, NMAX - 1, 1'b1);
    lk[r + $urandom_range(3, 9)] = 1'b0;
    run_scn("stable_glitch_rand", 90, -1);

    clear_stim();
    swv[80] = 1'b1;
    set_lk(95, NMAX - 1, 1'b1);
    run_scn("no_lock_fault", 200, -1);

    clear_stim();
    r = P + 2;
    set_lk(r, NMAX - 1, 1'b1);
    set_lk(r + 35, r + 35 + $urandom_range(0, 3), 1'b0);
    run_scn("run_lock_loss", 150, -1);

    clear_stim();
    for (int k = 0; k < NMAX; k++) swv[k] = 1'b1;
    set_lk(P + 1, NMAX - 1, 1'b1);
    run_scn("sw_relock_held", 200, -1);

    clear_stim();
    set_lk(P + 2, NMAX - 1, 1'b1);
    run_scn("rst_in_release", 200, 21);

    clear_stim();
    set_lk(P + 2, NMAX - 1, 1'b1);
    run_scn("after_rst", 80, -1);

    for (int k = 0; k < 6; k++) begin
      clear_stim();
      x = 0; v = 1'b0;
      while (x < NMAX) begin
        len = v ? $urandom_range(3, 60) : $urandom_range(1, 30);
        set_lk(x, x + len - 1, v);
        x += len;
        v = ~v;
      end
      for (int j = 0; j < NMAX; j++) swv[j] = ($urandom_range(0, 39) == 0);
      run_scn("random", 300, -1);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
